// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: opcode constants and the
// buffered {pc, instr} entry carried from fetch to decode.
package fetch_pkg;

  localparam logic [5:0]  OP_J = 6'b000010;
  localparam logic [31:0] NOP  = 32'h0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // True when the word is a J-type jump that fetch resolves locally.
  function automatic logic is_jump(input logic [31:0] instr);
    return instr[31:26] == OP_J;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO of fetch entries between fetch and decode.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   push, wr_entry    write wr_entry at the tail
//   pop               drop the head entry
//   flush             empty the buffer; dominates push and pop
//   rd_entry_c        head entry (meaningful only when !empty)
//   full, empty       occupancy flags
//   count             number of valid entries (0..DEPTH)
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  fetch_entry_t       wr_entry,
  output fetch_entry_t       rd_entry_c,
  output logic               full,
  output logic               empty,
  output logic [CNT_W-1:0]   count
);

  fetch_entry_t           mem_q [DEPTH];
  fetch_entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;

  // Next-state: pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wr_entry;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_entry_c = mem_q[rd_ptr_q];
  assign count      = count_q;
  assign full       = (count_q == CNT_W'(DEPTH));
  assign empty      = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads a combinational instruction
// memory, resolves J-type jumps locally and queues fetched words for decode.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   imem_addr / imem_data           word address out, instruction word in
//   redirect_valid / redirect_pc    PC override from later stages
//   if_valid / if_ready             decode handshake
//   if_instr / if_pc                head instruction and its PC (0 when empty)
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      pc_q, pc_d;
  logic             handshake_c;
  logic             pop_c;
  logic             push_c;
  logic             buf_full;
  logic             buf_empty;
  logic [CNT_W-1:0] buf_count;
  fetch_entry_t     wr_entry_c;
  fetch_entry_t     head_c;

  // A redirect discards the handshake and suppresses the fetch this cycle.
  assign handshake_c = if_valid && if_ready;
  assign pop_c       = handshake_c && !redirect_valid;
  assign push_c      = !redirect_valid && (!buf_full || handshake_c);
  assign wr_entry_c  = '{pc: pc_q, instr: imem_data};

  // Next PC: redirect > jump > sequential; hold when nothing is fetched.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (push_c) begin
      if (is_jump(imem_data)) begin
        pc_d = {pc_q[31:26], imem_data[25:0]};
      end else begin
        pc_d = pc_q + 32'd1;
      end
    end
  end

  // PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_buffer #(
    .DEPTH (DEPTH)
  ) u_buffer (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push_c),
    .pop        (pop_c),
    .flush      (redirect_valid),
    .wr_entry   (wr_entry_c),
    .rd_entry_c (head_c),
    .full       (buf_full),
    .empty      (buf_empty),
    .count      (buf_count)
  );

  assign imem_addr = pc_q;
  assign if_valid  = (buf_count != '0);
  assign if_instr  = buf_empty ? NOP : head_c.instr;
  assign if_pc     = buf_empty ? 32'h0 : head_c.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic, checked
// every cycle against a queue-based model of the fetch stage.
module tb_fetch_unit;

  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [64];
  assign imem_data = mem[imem_addr[5:0]];

  // Reference model: queue of {pc, instr} and the fetch PC.
  logic [63:0] m_q [$];
  logic [31:0] m_pc;

  fetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [63:0] head;
    head = (m_q.size() != 0) ? m_q[0] : 64'h0;
    check_eq("imem_addr", imem_addr, m_pc);
    check_eq("if_valid", {31'h0, if_valid}, {31'h0, m_q.size() != 0});
    check_eq("if_pc", if_pc, head[63:32]);
    check_eq("if_instr", if_instr, head[31:0]);
  endtask

  // Called at a falling edge: check, drive inputs, advance model across the
  // next rising edge, then wait for the following falling edge.
  task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rpc);
    logic        pop;
    logic        push;
    logic [31:0] word;
    check_outputs();
    if_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    if (rv) begin
      m_q.delete();
      m_pc = rpc;
    end else begin
      pop  = (m_q.size() != 0) && rdy;
      push = (m_q.size() < DEPTH) || pop;
      word = mem[m_pc[5:0]];
      if (pop) void'(m_q.pop_front());
      if (push) begin
        m_q.push_back({m_pc, word});
        if (word[31:26] == 6'b000010) m_pc = {m_pc[31:26], word[25:0]};
        else                          m_pc = m_pc + 32'd1;
      end
    end
    @(negedge clk);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_imem_addr", imem_addr, RESET_PC);
    check_eq("rst_if_valid", {31'h0, if_valid}, 32'h0);
    check_eq("rst_if_pc", if_pc, 32'h0);
    check_eq("rst_if_instr", if_instr, 32'h0);
    m_q.delete();
    m_pc = RESET_PC;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n          = 1'b0;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    for (int i = 0; i < 64; i++) mem[i] = {6'h0, 26'(i * 3 + 1)};
    mem[5] = 32'h0800_0008;
    m_q.delete();
    m_pc = RESET_PC;

    @(negedge clk);
    do_reset();

    // Straight-line fetch through a jump at word 5.
    repeat (12) cycle(1'b1, 1'b0, 32'h0);

    // Stall from reset, then drain.
    do_reset();
    repeat (5) cycle(1'b0, 1'b0, 32'h0);
    repeat (6) cycle(1'b1, 1'b0, 32'h0);

    // Full buffer with a single-cycle ready.
    repeat (3) cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    repeat (2) cycle(1'b0, 1'b0, 32'h0);

    // Redirect while full, then redirect colliding with a pop.
    cycle(1'b0, 1'b1, 32'h20);
    repeat (4) cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h40);
    repeat (3) cycle(1'b1, 1'b0, 32'h0);

    // PC wrap from the top of the address space.
    cycle(1'b1, 1'b1, 32'hFFFF_FFFF);
    repeat (4) cycle(1'b1, 1'b0, 32'h0);

    // Reset mid-stream with a full buffer.
    repeat (3) cycle(1'b0, 1'b0, 32'h0);
    do_reset();
    repeat (5) cycle(1'b1, 1'b0, 32'h0);

    // Randomized traffic with jumps, stalls and redirects.
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 4) == 0) mem[i] = {6'b000010, 26'($urandom)};
      else                           mem[i] = $urandom;
    end
    for (int n = 0; n < 400; n++) begin
      logic        rdy;
      logic        rv;
      logic [31:0] rpc;
      rdy = ($urandom_range(0, 9) < 7);
      rv  = ($urandom_range(0, 19) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 2))) : $urandom;
      cycle(rdy, rv, rpc);
    end
    check_outputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
